decode_ctrl_stage: RTL and testbench
====================================

# decode_ctrl_stage

Registered RV32I decode/control stage: the successor to the combinational control block. It decodes the full base opcode map, generates the immediate, flags illegal encodings and presents all control fields from a single pipeline register with a valid/ready handshake. It sits between the fetch stage and the register-file/ALU stage and supports stall (backpressure) and flush (branch redirect).

## Interface
- `XLEN`, 32: datapath width for `pc` and `imm`. Only 32 is legal.
- `ALUOP_W`, 5: width of `alu_op`. Must be ≥5.
- `ILL_CNT_W`, 8: width of the illegal-instruction counter.

Ports:
- `clk`  in  1  clock, rising edge.
- `rst_n`  in  1  reset, asynchronous, active-low.
- `in_valid`  in  1  instruction and pc valid.
- `in_ready`  out  1  stage can accept this cycle.
- `instr`  in  32  raw instruction.
- `pc_in`  in  XLEN  instruction address.
- `flush`  in  1  discard the held and incoming instruction.
- `out_valid`  out  1  registered control fields valid.
- `out_ready`  in  1  downstream accepts.
- `pc_out`  out  XLEN  registered pc.
- `rs1`, `rs2`, `rd`  out  5 each  register indices.
- `imm`  out  XLEN  sign-extended immediate.
- `alu_op`  out  ALUOP_W  ALU operation.
- `reg_wen`  out  1  rd write enable; forced 0 when `rd`==0.
- `b_sel`  out  1  1 selects `imm` as ALU operand B.
- `a_sel`  out  1  1 selects pc as ALU operand A.
- `mem_ren`, `mem_wen`  out  1 each  load/store.
- `mem_size`  out  3  `func3` for loads/stores.
- `branch`, `jump`  out  1 each  conditional branch / JAL or JALR.
- `wb_sel`  out  2  0=ALU, 1=memory, 2=pc+4.
- `illegal`  out  1  held instruction is an unsupported encoding.
- `ill_count`  out  ILL_CNT_W  saturating count of illegal instructions accepted.

## Operation
- ALU op codes: ADD 0, SUB 1, AND 2, OR 3, XOR 4, SLL 5, SRL 6, SRA 7, SLT 8, SLTU 9, PASSB 10; with the M extension, MUL..REMU 16..23 in `func3` order.
- R-type (0110011): `func7`=0000000 selects ADD/SLL/SLT/SLTU/XOR/SRL/OR/AND by `func3`; `func7`=0100000 is valid only with `func3` 000 (SUB) or 101 (SRA). Any other `func7` is illegal.
- I-ALU (0010011): `b_sel`=1. SLLI requires `func7`=0000000. SRLI/SRAI are selected by `func7` 0000000/0100000; any other value is illegal.
- LOAD 0000011, STORE 0100011, BRANCH 1100011, JAL 1101111, JALR 1100111, LUI 0110111 (PASSB), AUIPC 0010111 (`a_sel`=1, ADD). Immediates use the I/S/B/U/J formats.
- Any other opcode, or a reserved `func3` for LOAD/STORE/BRANCH/JALR, sets `illegal`=1. All enables (`reg_wen`, `mem_*`, `branch`, `jump`) are then 0 and `alu_op`=0.
- `ill_count` increments on each accepted illegal instruction and saturates at all-ones.

## Timing
- Reset: every output is 0, including `out_valid`, `ill_count` and `in_ready`=1 (the stage is empty).
- `in_ready` = !`out_valid` || `out_ready`. This is combinational and has no dependence on `in_valid`.
- Accept when `in_valid` && `in_ready`. The fields are registered and appear with `out_valid`=1 on the next cycle, giving a latency of 1.
- A held instruction stays stable while `out_valid` && !`out_ready`.
- When `flush` is asserted, `out_valid`=0 on the next edge and the incoming instruction is dropped, even if it was accepted in the same cycle. `ill_count` does not count flushed instructions.
- Accept and drain in the same cycle gives back-to-back throughput of 1 instruction/cycle.
- Asserting `rst_n` mid-operation drops the held instruction immediately.

## Configuration
- `DECODE_MULDIV_EN`: when defined, R-type with `func7`=0000001 decodes to ALU ops 16..23.
- When the macro is undefined, that encoding is illegal.

## Structure
- Package `decode_pkg` holds:
  - the opcode localparams;
  - the `alu_op` enum;
  - the `wb_sel` encoding;
  - the immediate-format enum.
- Sub-module `imm_gen` is a combinational immediate generator selected by format.

## Test plan
- `add x3,x1,x2` (0x002081B3), `out_ready`=1 → one cycle later `alu_op`=0, `reg_wen`=1, `rd`=3, `b_sel`=0, `illegal`=0.
- `srai x5,x6,3` (0x40335293) → `alu_op`=7, `b_sel`=1, `imm`=0x403. R-type `func7`=0x7F → `illegal`=1, `ill_count` 0→1.
- `sw x2,-4(x1)` (0xFE20AE23) → `mem_wen`=1, `reg_wen`=0, `imm`=0xFFFFFFFC; `jal x1,8` → `jump`=1, `wb_sel`=2.
- Hold `out_ready`=0 for 3 cycles with `in_valid`=1 → `in_ready`=0 and outputs stable; release → next instruction appears one cycle later, nothing lost.
- `flush` with `in_valid` accepted → `out_valid`=0 next cycle; an illegal instruction flushed this way leaves `ill_count` unchanged. Drive 300 illegal instructions → `ill_count`=255.
- `mul` (0x022081B3) → `alu_op`=16 with `DECODE_MULDIV_EN` defined, `illegal`=1 without it. Pulse `rst_n` low mid-stream → all outputs 0 asynchronously.

Source files
------------

// File: rtl/decode_pkg.sv
// Shared decode definitions for the RV32I decode/control stage.
// The optional M-extension decode in decode_ctrl_stage is enabled by DECODE_MULDIV_EN.
package decode_pkg;

  localparam logic [6:0] OPC_LOAD   = 7'b0000011;
  localparam logic [6:0] OPC_OP_IMM = 7'b0010011;
  localparam logic [6:0] OPC_AUIPC  = 7'b0010111;
  localparam logic [6:0] OPC_STORE  = 7'b0100011;
  localparam logic [6:0] OPC_OP     = 7'b0110011;
  localparam logic [6:0] OPC_LUI    = 7'b0110111;
  localparam logic [6:0] OPC_BRANCH = 7'b1100011;
  localparam logic [6:0] OPC_JALR   = 7'b1100111;
  localparam logic [6:0] OPC_JAL    = 7'b1101111;

  localparam logic [6:0] F7_BASE   = 7'b0000000;
  localparam logic [6:0] F7_ALT    = 7'b0100000;
  localparam logic [6:0] F7_MULDIV = 7'b0000001;

  typedef enum logic [4:0] {
    ALU_ADD    = 5'd0,
    ALU_SUB    = 5'd1,
    ALU_AND    = 5'd2,
    ALU_OR     = 5'd3,
    ALU_XOR    = 5'd4,
    ALU_SLL    = 5'd5,
    ALU_SRL    = 5'd6,
    ALU_SRA    = 5'd7,
    ALU_SLT    = 5'd8,
    ALU_SLTU   = 5'd9,
    ALU_PASSB  = 5'd10,
    ALU_MUL    = 5'd16,
    ALU_MULH   = 5'd17,
    ALU_MULHSU = 5'd18,
    ALU_MULHU  = 5'd19,
    ALU_DIV    = 5'd20,
    ALU_DIVU   = 5'd21,
    ALU_REM    = 5'd22,
    ALU_REMU   = 5'd23
  } alu_op_e;

  typedef enum logic [1:0] {
    WB_ALU = 2'd0,
    WB_MEM = 2'd1,
    WB_PC4 = 2'd2
  } wb_sel_e;

  typedef enum logic [2:0] {
    IMM_NONE = 3'd0,
    IMM_I    = 3'd1,
    IMM_S    = 3'd2,
    IMM_B    = 3'd3,
    IMM_U    = 3'd4,
    IMM_J    = 3'd5
  } imm_fmt_e;

  typedef struct packed {
    alu_op_e    alu_op;
    logic       reg_wen;
    logic       b_sel;
    logic       a_sel;
    logic       mem_ren;
    logic       mem_wen;
    logic [2:0] mem_size;
    logic       branch;
    logic       jump;
    wb_sel_e    wb_sel;
    logic       illegal;
  } ctrl_t;

  // Base integer op selected by func3 when func7 is the plain encoding.
  function automatic alu_op_e alu_base(input logic [2:0] f3);
    case (f3)
      3'b000:  return ALU_ADD;
      3'b001:  return ALU_SLL;
      3'b010:  return ALU_SLT;
      3'b011:  return ALU_SLTU;
      3'b100:  return ALU_XOR;
      3'b101:  return ALU_SRL;
      3'b110:  return ALU_OR;
      default: return ALU_AND;
    endcase
  endfunction

endpackage

// File: rtl/imm_gen.sv
// Combinational immediate generator: assembles the sign-extended immediate
// for the selected RV32I instruction format.
module imm_gen
  import decode_pkg::*;
#(
  parameter int XLEN = 32
) (
  input  logic [31:7]     instr,
  input  imm_fmt_e        fmt,
  output logic [XLEN-1:0] imm
);

  logic signed [31:0] imm32;

  // Format-selected bit gathering; every format sign-extends from instr[31].
  always_comb begin
    imm32 = '0;
    case (fmt)
      IMM_I:   imm32 = $signed({{20{instr[31]}}, instr[31:20]});
      IMM_S:   imm32 = $signed({{20{instr[31]}}, instr[31:25], instr[11:7]});
      IMM_B:   imm32 = $signed({{19{instr[31]}}, instr[31], instr[7], instr[30:25],
                                instr[11:8], 1'b0});
      IMM_U:   imm32 = $signed({instr[31:12], 12'b0});
      IMM_J:   imm32 = $signed({{11{instr[31]}}, instr[31], instr[19:12], instr[20],
                                instr[30:21], 1'b0});
      default: imm32 = '0;
    endcase
  end

  assign imm = XLEN'(imm32);

endmodule

// File: rtl/decode_ctrl_stage.sv
// Registered RV32I decode/control stage with valid/ready handshake, flush and
// a saturating illegal-instruction counter.
// DECODE_MULDIV_EN: when defined, R-type func7=0000001 decodes to MUL..REMU.
module decode_ctrl_stage
  import decode_pkg::*;
#(
  parameter int XLEN      = 32,
  parameter int ALUOP_W   = 5,
  parameter int ILL_CNT_W = 8
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 in_valid,
  output logic                 in_ready,
  input  logic [31:0]          instr,
  input  logic [XLEN-1:0]      pc_in,
  input  logic                 flush,
  output logic                 out_valid,
  input  logic                 out_ready,
  output logic [XLEN-1:0]      pc_out,
  output logic [4:0]           rs1,
  output logic [4:0]           rs2,
  output logic [4:0]           rd,
  output logic [XLEN-1:0]      imm,
  output logic [ALUOP_W-1:0]   alu_op,
  output logic                 reg_wen,
  output logic                 b_sel,
  output logic                 a_sel,
  output logic                 mem_ren,
  output logic                 mem_wen,
  output logic [2:0]           mem_size,
  output logic                 branch,
  output logic                 jump,
  output logic [1:0]           wb_sel,
  output logic                 illegal,
  output logic [ILL_CNT_W-1:0] ill_count
);

  logic [6:0] opcode, f7;
  logic [2:0] f3;
  ctrl_t      dec;
  imm_fmt_e   imm_fmt;
  logic [XLEN-1:0] imm_dec;
  logic       accept;

  ctrl_t                ctrl_d, ctrl_q;
  logic [XLEN-1:0]      pc_d, pc_q, imm_d, imm_q;
  logic [4:0]           rs1_d, rs1_q, rs2_d, rs2_q, rd_d, rd_q;
  logic                 out_valid_d, out_valid_q;
  logic [ILL_CNT_W-1:0] ill_count_d, ill_count_q;

  assign opcode = instr[6:0];
  assign f3     = instr[14:12];
  assign f7     = instr[31:25];

  imm_gen #(.XLEN(XLEN)) u_imm_gen (
    .instr (instr[31:7]),
    .fmt   (imm_fmt),
    .imm   (imm_dec)
  );

  // Opcode/func decode; an illegal encoding clears every enable afterwards.
  always_comb begin
    logic ill;
    dec     = '0;
    imm_fmt = IMM_NONE;
    ill     = 1'b0;
    case (opcode)
      OPC_OP: begin
        dec.reg_wen = 1'b1;
        if (f7 == F7_BASE) begin
          dec.alu_op = alu_base(f3);
        end else if (f7 == F7_ALT && f3 == 3'b000) begin
          dec.alu_op = ALU_SUB;
        end else if (f7 == F7_ALT && f3 == 3'b101) begin
          dec.alu_op = ALU_SRA;
`ifdef DECODE_MULDIV_EN
        end else if (f7 == F7_MULDIV) begin
          dec.alu_op = alu_op_e'({2'b10, f3});
`endif
        end else begin
          ill = 1'b1;
        end
      end
      OPC_OP_IMM: begin
        dec.reg_wen = 1'b1;
        dec.b_sel   = 1'b1;
        imm_fmt     = IMM_I;
        dec.alu_op  = alu_base(f3);
        if (f3 == 3'b001 && f7 != F7_BASE) ill = 1'b1;
        if (f3 == 3'b101) begin
          if (f7 == F7_ALT)       dec.alu_op = ALU_SRA;
          else if (f7 != F7_BASE) ill = 1'b1;
        end
      end
      OPC_LOAD: begin
        dec.reg_wen  = 1'b1;
        dec.mem_ren  = 1'b1;
        dec.b_sel    = 1'b1;
        dec.mem_size = f3;
        dec.wb_sel   = WB_MEM;
        imm_fmt      = IMM_I;
        if (f3 == 3'b011 || f3 == 3'b110 || f3 == 3'b111) ill = 1'b1;
      end
      OPC_STORE: begin
        dec.mem_wen  = 1'b1;
        dec.b_sel    = 1'b1;
        dec.mem_size = f3;
        imm_fmt      = IMM_S;
        if (f3[2] || f3 == 3'b011) ill = 1'b1;
      end
      OPC_BRANCH: begin
        dec.branch = 1'b1;
        imm_fmt    = IMM_B;
        dec.alu_op = f3[2] ? (f3[1] ? ALU_SLTU : ALU_SLT) : ALU_SUB;
        if (f3 == 3'b010 || f3 == 3'b011) ill = 1'b1;
      end
      OPC_JAL: begin
        dec.reg_wen = 1'b1;
        dec.jump    = 1'b1;
        dec.a_sel   = 1'b1;
        dec.b_sel   = 1'b1;
        dec.wb_sel  = WB_PC4;
        imm_fmt     = IMM_J;
      end
      OPC_JALR: begin
        dec.reg_wen = 1'b1;
        dec.jump    = 1'b1;
        dec.b_sel   = 1'b1;
        dec.wb_sel  = WB_PC4;
        imm_fmt     = IMM_I;
        if (f3 != 3'b000) ill = 1'b1;
      end
      OPC_LUI: begin
        dec.reg_wen = 1'b1;
        dec.b_sel   = 1'b1;
        dec.alu_op  = ALU_PASSB;
        imm_fmt     = IMM_U;
      end
      OPC_AUIPC: begin
        dec.reg_wen = 1'b1;
        dec.a_sel   = 1'b1;
        dec.b_sel   = 1'b1;
        imm_fmt     = IMM_U;
      end
      default: ill = 1'b1;
    endcase
    if (ill) begin
      dec         = '0;
      dec.illegal = 1'b1;
      imm_fmt     = IMM_NONE;
    end
    if (instr[11:7] == 5'd0) dec.reg_wen = 1'b0;
  end

  assign in_ready = !out_valid_q || out_ready;
  assign accept   = in_valid && in_ready && !flush;

  // Pipeline register next-state: load on accept, drain on out_ready, kill on flush.
  always_comb begin
    ctrl_d      = ctrl_q;
    pc_d        = pc_q;
    imm_d       = imm_q;
    rs1_d       = rs1_q;
    rs2_d       = rs2_q;
    rd_d        = rd_q;
    ill_count_d = ill_count_q;
    out_valid_d = out_valid_q && !out_ready;
    if (accept) begin
      ctrl_d      = dec;
      pc_d        = pc_in;
      imm_d       = imm_dec;
      rs1_d       = instr[19:15];
      rs2_d       = instr[24:20];
      rd_d        = instr[11:7];
      out_valid_d = 1'b1;
      if (dec.illegal && ill_count_q != '1)
        ill_count_d = ill_count_q + ILL_CNT_W'(1);
    end
    if (flush) out_valid_d = 1'b0;
  end

  // State registers; async reset empties the stage and clears all fields.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ctrl_q      <= '0;
      pc_q        <= '0;
      imm_q       <= '0;
      rs1_q       <= '0;
      rs2_q       <= '0;
      rd_q        <= '0;
      out_valid_q <= 1'b0;
      ill_count_q <= '0;
    end else begin
      ctrl_q      <= ctrl_d;
      pc_q        <= pc_d;
      imm_q       <= imm_d;
      rs1_q       <= rs1_d;
      rs2_q       <= rs2_d;
      rd_q        <= rd_d;
      out_valid_q <= out_valid_d;
      ill_count_q <= ill_count_d;
    end
  end

  assign out_valid = out_valid_q;
  assign pc_out    = pc_q;
  assign imm       = imm_q;
  assign rs1       = rs1_q;
  assign rs2       = rs2_q;
  assign rd        = rd_q;
  assign alu_op    = ALUOP_W'(ctrl_q.alu_op);
  assign reg_wen   = ctrl_q.reg_wen;
  assign b_sel     = ctrl_q.b_sel;
  assign a_sel     = ctrl_q.a_sel;
  assign mem_ren   = ctrl_q.mem_ren;
  assign mem_wen   = ctrl_q.mem_wen;
  assign mem_size  = ctrl_q.mem_size;
  assign branch    = ctrl_q.branch;
  assign jump      = ctrl_q.jump;
  assign wb_sel    = ctrl_q.wb_sel;
  assign illegal   = ctrl_q.illegal;
  assign ill_count = ill_count_q;

endmodule

// File: tb/tb_decode_ctrl_stage.sv
// Directed bench for decode_ctrl_stage: decode fields, handshake, flush,
// counter saturation and asynchronous reset.
module tb_decode_ctrl_stage;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        in_valid, in_ready, flush, out_valid, out_ready;
  logic [31:0] instr, pc_in, pc_out, imm;
  logic [4:0]  rs1, rs2, rd, alu_op;
  logic        reg_wen, b_sel, a_sel, mem_ren, mem_wen, branch, jump, illegal;
  logic [2:0]  mem_size;
  logic [1:0]  wb_sel;
  logic [7:0]  ill_count;

  int checks = 0;
  int errors = 0;

  decode_ctrl_stage dut (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
    .instr(instr), .pc_in(pc_in), .flush(flush), .out_valid(out_valid),
    .out_ready(out_ready), .pc_out(pc_out), .rs1(rs1), .rs2(rs2), .rd(rd),
    .imm(imm), .alu_op(alu_op), .reg_wen(reg_wen), .b_sel(b_sel), .a_sel(a_sel),
    .mem_ren(mem_ren), .mem_wen(mem_wen), .mem_size(mem_size), .branch(branch),
    .jump(jump), .wb_sel(wb_sel), .illegal(illegal), .ill_count(ill_count)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic send(input logic [31:0] ins, input logic [31:0] pc);
    in_valid  = 1'b1;
    instr     = ins;
    pc_in     = pc;
    out_ready = 1'b1;
    flush     = 1'b0;
    tick();
    in_valid  = 1'b0;
  endtask

  initial begin
    rst_n = 1'b0; in_valid = 1'b0; flush = 1'b0; out_ready = 1'b0;
    instr = '0; pc_in = '0;
    #12;
    chk("rst_out_valid", out_valid, 0);
    chk("rst_in_ready", in_ready, 1);
    chk("rst_ill_count", ill_count, 0);
    chk("rst_imm", imm, 0);
    chk("rst_reg_wen", reg_wen, 0);
    chk("rst_pc_out", pc_out, 0);
    @(negedge clk);
    rst_n = 1'b1;
    tick();

    send(32'h002081B3, 32'h100);
    chk("add_valid", out_valid, 1);
    chk("add_alu", alu_op, 0);
    chk("add_wen", reg_wen, 1);
    chk("add_rd", rd, 3);
    chk("add_rs1", rs1, 1);
    chk("add_rs2", rs2, 2);
    chk("add_bsel", b_sel, 0);
    chk("add_ill", illegal, 0);
    chk("add_pc", pc_out, 32'h100);

    send(32'h40335293, 32'h104);
    chk("srai_alu", alu_op, 7);
    chk("srai_bsel", b_sel, 1);
    chk("srai_imm", imm, 32'h403);
    chk("srai_rd", rd, 5);

    send(32'hFE2081B3, 32'h108);
    chk("badr_ill", illegal, 1);
    chk("badr_wen", reg_wen, 0);
    chk("badr_alu", alu_op, 0);
    chk("badr_cnt", ill_count, 1);

    send(32'hFE20AE23, 32'h10C);
    chk("sw_mwen", mem_wen, 1);
    chk("sw_wen", reg_wen, 0);
    chk("sw_imm", imm, 32'hFFFFFFFC);
    chk("sw_size", mem_size, 2);

    send(32'h008000EF, 32'h110);
    chk("jal_jump", jump, 1);
    chk("jal_wb", wb_sel, 2);
    chk("jal_imm", imm, 8);
    chk("jal_wen", reg_wen, 1);
    chk("jal_asel", a_sel, 1);

    send(32'h00812203, 32'h114);
    chk("lw_mren", mem_ren, 1);
    chk("lw_wb", wb_sel, 1);
    chk("lw_imm", imm, 8);

    send(32'h00000013, 32'h118);
    chk("nop_wen_x0", reg_wen, 0);
    chk("nop_ill", illegal, 0);

    send(32'h123452B7, 32'h11C);
    chk("lui_alu", alu_op, 10);
    chk("lui_imm", imm, 32'h12345000);

    // Stall: A held while out_ready is low, B waits at the input.
    send(32'h00100093, 32'h200);
    in_valid = 1'b1; instr = 32'h00200113; pc_in = 32'h204; out_ready = 1'b0;
    #1;
    chk("stall_in_ready", in_ready, 0);
    for (int i = 0; i < 3; i++) begin
      tick();
      chk("stall_rd", rd, 1);
      chk("stall_imm", imm, 1);
      chk("stall_valid", out_valid, 1);
    end
    out_ready = 1'b1;
    tick();
    in_valid = 1'b0;
    chk("release_rd", rd, 2);
    chk("release_pc", pc_out, 32'h204);
    tick();
    chk("drain_valid", out_valid, 0);

    // Flush drops an accepted illegal instruction without counting it.
    in_valid = 1'b1; instr = 32'h00000000; flush = 1'b1; out_ready = 1'b1;
    tick();
    in_valid = 1'b0; flush = 1'b0;
    chk("flush_valid", out_valid, 0);
    chk("flush_cnt", ill_count, 1);

    // Flush kills a held instruction.
    send(32'h002081B3, 32'h300);
    out_ready = 1'b0; flush = 1'b1;
    tick();
    flush = 1'b0;
    chk("flush_held", out_valid, 0);

    // Back-to-back illegal stream saturates the counter.
    in_valid = 1'b1; instr = 32'h00000000; out_ready = 1'b1;
    repeat (253) tick();
    chk("cnt_254", ill_count, 254);
    repeat (47) tick();
    in_valid = 1'b0;
    chk("cnt_sat", ill_count, 255);

    send(32'h022081B3, 32'h400);
`ifdef DECODE_MULDIV_EN
    chk("mul_alu", alu_op, 16);
    chk("mul_ill", illegal, 0);
`else
    chk("mul_ill", illegal, 1);
    chk("mul_alu", alu_op, 0);
`endif

    // Asynchronous reset mid-stream.
    send(32'h002081B3, 32'h500);
    out_ready = 1'b0;
    #2;
    rst_n = 1'b0;
    #1;
    chk("arst_valid", out_valid, 0);
    chk("arst_rd", rd, 0);
    chk("arst_wen", reg_wen, 0);
    chk("arst_cnt", ill_count, 0);
    chk("arst_in_ready", in_ready, 1);
    @(negedge clk);
    rst_n = 1'b1;
    tick();
    send(32'h40335293, 32'h600);
    chk("post_rst_alu", alu_op, 7);
    chk("post_rst_pc", pc_out, 32'h600);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
